sfq_and_driver: RTL and testbench

- Transmitter/stimulus end for the pulse-encoded clocked AND cell.
- Accepts synchronous operand pairs over a valid/ready handshake.
- Encodes each operand pair as toggle pulses on the cell's a, b and clk inputs, spaced to clear the cell's 2.5 ps critical-timing windows.
- Watches the cell's toggle-encoded out line and reports the received result plus a mismatch/error flag. Used in benches and in the test harness that wraps SFQ gate models.

---
 rtl/sfq_and_driver_if.sv | 31 +++
 rtl/sfq_and_driver.sv | 177 +++++++++++++++++
 tb/tb_sfq_and_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sfq_and_driver_if.sv
// Bundle between the SFQ AND-cell driver and its host: operand handshake,
// toggle-encoded pulse lines to/from the cell, the result strobe and FSM debug state.
//
// Handshake: an operand pair transfers on the rising clk edge where in_valid
// and in_ready are both 1. in_a/in_b are only sampled on that edge. in_ready never
// depends combinationally on in_valid. res_valid is a one-cycle strobe with no backpressure.
interface sfq_and_driver_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_a;
    logic       in_b;
    logic       pa;
    logic       pb;
    logic       pclk;
    logic       pout;
    logic       res_valid;
    logic       res_out;
    logic       res_err;
    logic       busy;
    logic [3:0] dbg_state;

    modport master (
        output in_valid, in_a, in_b, pout,
        input  in_ready, pa, pb, pclk, res_valid, res_out, res_err, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_a, in_b, pout,
        output in_ready, pa, pb, pclk, res_valid, res_out, res_err, busy, dbg_state
    );
endinterface

// File: rtl/sfq_and_driver.sv
// Stimulus driver for a pulse-encoded clocked SFQ AND cell: emits a/b/clk toggles
// on a fixed schedule, then counts synchronised out toggles and reports the result.
module sfq_and_driver #(
    parameter int SEP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int INIT_CYCLES    = 8
) (
    input logic            clk,
    input logic            rst_n,
    sfq_and_driver_if.slave bus
);
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SEND_A, S_GAP_A, S_SEND_B,
        S_GAP_B, S_SEND_CLK, S_WAIT, S_REPORT
    } state_t;

    localparam int MAX_AB = (SEP_CYCLES > TIMEOUT_CYCLES) ? SEP_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_AB > INIT_CYCLES) ? MAX_AB : INIT_CYCLES;
    localparam int TW     = $clog2(MAX_C + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          a_q, a_d, b_q, b_d;
    logic          pa_q, pa_d, pb_q, pb_d, pclk_q, pclk_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          stray_q, stray_d;
    logic          in_ready_q, in_ready_d;
    logic          res_valid_q, res_valid_d;
    logic          res_out_q, res_out_d;
    logic          res_err_q, res_err_d;
    logic          busy_q, busy_d;
    logic          edge_det;

    // One edge of the synchronised out line is one cell pulse.
    assign edge_det = sync2_q ^ prev_q;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        a_d         = a_q;
        b_d         = b_q;
        pa_d        = pa_q;
        pb_d        = pb_q;
        pclk_d      = pclk_q;
        sync1_d     = bus.pout;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        cnt_d       = cnt_q;
        stray_d     = stray_q | edge_det;
        res_valid_d = 1'b0;
        res_out_d   = 1'b0;
        res_err_d   = 1'b0;

        case (state_q)
            S_INIT: begin
                if (tmr_q == TW'(INIT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    state_d = S_SEND_A;
                end
            end
            S_SEND_A: begin
                pa_d    = pa_q ^ a_q;
                tmr_d   = '0;
                state_d = (SEP_CYCLES > 1) ? S_GAP_A : S_SEND_B;
            end
            S_GAP_A: begin
                if (tmr_q == TW'(SEP_CYCLES - 2)) begin
                    state_d = S_SEND_B;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SEND_B: begin
                pb_d    = pb_q ^ b_q;
                tmr_d   = '0;
                state_d = (SEP_CYCLES > 1) ? S_GAP_B : S_SEND_CLK;
            end
            S_GAP_B: begin
                if (tmr_q == TW'(SEP_CYCLES - 2)) begin
                    state_d = S_SEND_CLK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SEND_CLK: begin
                pclk_d  = ~pclk_q;
                tmr_d   = '0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Edges inside the window are the cell's answer, not strays.
                stray_d = stray_q;
                if (edge_det && (cnt_q != 2'd3)) cnt_d = cnt_q + 2'd1;
                if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_REPORT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_REPORT: begin
                res_valid_d = 1'b1;
                res_out_d   = (cnt_q != 2'd0);
                res_err_d   = (cnt_q != {1'b0, a_q & b_q}) | cnt_q[1] | stray_q;
                stray_d     = edge_det;
                state_d     = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = !((state_d == S_INIT) || (state_d == S_IDLE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            tmr_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            pa_q        <= 1'b0;
            pb_q        <= 1'b0;
            pclk_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            stray_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_out_q   <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pa_q        <= pa_d;
            pb_q        <= pb_d;
            pclk_q      <= pclk_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            stray_q     <= stray_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.pa        = pa_q;
    assign bus.pb        = pb_q;
    assign bus.pclk      = pclk_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_out   = res_out_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sfq_and_driver.sv
// Bench for sfq_and_driver: scripted operand pairs against a scripted cell,
// per-cycle pulse schedule checks and a result scoreboard.
module tb_sfq_and_driver;
  localparam int SEP  = 4;
  localparam int TO   = 8;
  localparam int INIT = 8;
  localparam int LAT  = 2 + 2*SEP + TO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfq_and_driver_if bus ();

  sfq_and_driver #(
    .SEP_CYCLES(SEP), .TIMEOUT_CYCLES(TO), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int last_e0 = 0;
  logic [1:0] exp_q[$];   // {res_out, res_err}
  logic [1:0] exp_r;

  always @(posedge clk) cyc++;

  // Result scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL result_unexpected: got out=%0b err=%0b, none expected", bus.res_out, bus.res_err);
      end else begin
        exp_r = exp_q.pop_front();
        if ({bus.res_out, bus.res_err} !== exp_r) begin
          n_mis++;
          $display("FAIL result: got out=%0b err=%0b, expected out=%0b err=%0b",
                   bus.res_out, bus.res_err, exp_r[1], exp_r[0]);
        end
      end
    end
  end

  // npulse: number of out toggles the scripted cell returns after pclk.
  task automatic drive_txn(input logic a, input logic b, input int npulse,
                           input logic exp_out, input logic exp_err, input string name);
    int waited;
    logic pa0, pb0, pclk0;
    logic [5:0] obs, expv;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL %s_ready: got in_ready=%b, expected 1 within 100 cycles", name, bus.in_ready);
      return;
    end
    pa0 = bus.pa; pb0 = bus.pb; pclk0 = bus.pclk;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(posedge clk); #1;
    last_e0 = cyc;
    exp_q.push_back({exp_out, exp_err});
    bus.in_valid = 1'b0;
    bus.in_a = 1'($urandom_range(0, 1));
    bus.in_b = 1'($urandom_range(0, 1));
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (npulse >= 1 && k == 2*SEP + 3) bus.pout = ~bus.pout;
      if (npulse >= 2 && k == 2*SEP + 5) bus.pout = ~bus.pout;
      expv = {pa0 ^ a, pb0 ^ (b & (k >= SEP + 1)), pclk0 ^ (k >= 2*SEP + 1),
              1'(k == LAT), 1'(k < LAT), 1'(k == LAT)};
      obs  = {bus.pa, bus.pb, bus.pclk, bus.res_valid, bus.busy, bus.in_ready};
      n_cmp++;
      if (obs !== expv) begin
        n_mis++;
        $display("FAIL %s_cycle%0d {pa,pb,pclk,res_valid,busy,in_ready}: got %b, expected %b",
                 name, k, obs, expv);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1; bus.pout = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.pa, bus.pb, bus.pclk, bus.in_ready, bus.res_valid, bus.res_out, bus.res_err, bus.busy} !== 8'b0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {bus.pa, bus.pb, bus.pclk, bus.in_ready, bus.res_valid, bus.res_out, bus.res_err, bus.busy});
    end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n != INIT) begin
      n_mis++;
      $display("FAIL reset_init_len: got in_ready after %0d cycles, expected %0d", n, INIT);
    end
  endtask

  task automatic test_and_11();     drive_txn(1'b1, 1'b1, 1, 1'b1, 1'b0, "and_11");     endtask
  task automatic test_and_00();     drive_txn(1'b0, 1'b0, 0, 1'b0, 1'b0, "and_00");     endtask
  task automatic test_err_10();     drive_txn(1'b1, 1'b0, 1, 1'b1, 1'b1, "err_10");     endtask
  task automatic test_timeout_11(); drive_txn(1'b1, 1'b1, 0, 1'b0, 1'b1, "timeout_11"); endtask
  task automatic test_and_01();     drive_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, "and_01");     endtask
  task automatic test_double();     drive_txn(1'b1, 1'b1, 2, 1'b1, 1'b1, "double");     endtask

  task automatic test_stray();
    repeat (3) @(posedge clk);
    #1;
    bus.pout = ~bus.pout;
    repeat (5) @(posedge clk);
    #1;
    drive_txn(1'b0, 1'b0, 0, 1'b0, 1'b1, "stray");
    drive_txn(1'b0, 1'b0, 0, 1'b0, 1'b0, "after_stray");
  endtask

  task automatic test_back_to_back();
    int e0a;
    drive_txn(1'b1, 1'b1, 1, 1'b1, 1'b0, "b2b_first");
    e0a = last_e0;
    drive_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, "b2b_second");
    n_cmp++;
    if (last_e0 - e0a != 3 + 2*SEP + TO) begin
      n_mis++;
      $display("FAIL b2b_interval: got %0d cycles, expected %0d", last_e0 - e0a, 3 + 2*SEP + TO);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.pout = 1'b0;
    #1;
    n_cmp++;
    if ({bus.pa, bus.pb, bus.pclk, bus.in_ready, bus.res_valid, bus.res_out, bus.res_err, bus.busy} !== 8'b0) begin
      n_mis++;
      $display("FAIL mid_reset_outputs: got %b, expected 00000000",
               {bus.pa, bus.pb, bus.pclk, bus.in_ready, bus.res_valid, bus.res_out, bus.res_err, bus.busy});
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n != INIT) begin
      n_mis++;
      $display("FAIL mid_reset_init_len: got in_ready after %0d cycles, expected %0d", n, INIT);
    end
    drive_txn(1'b1, 1'b1, 1, 1'b1, 1'b0, "post_reset");
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = 1'b0; bus.in_b = 1'b0; bus.pout = 1'b0;
    test_reset();
    test_and_11();
    test_and_00();
    test_err_10();
    test_timeout_11();
    test_and_01();
    test_double();
    test_stray();
    test_back_to_back();
    test_mid_reset();
    repeat (4) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL results_outstanding: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units, expected bench end");
    $fatal(1, "watchdog expired");
  end
endmodule
